driver_sout_reader: RTL and testbench



---
 rtl/driver_sout_reader.sv | 156 +++++++++++++++
 tb/tb_driver_sout_reader.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/driver_sout_reader.sv
// driver_sout_reader: deserialises one column's SOUT readback into 48-bit words
// and compares every word against the configuration that was just written.
`default_nettype none

module driver_sout_reader #(
    parameter int CONF_WIDTH = 48,
    parameter int CHAIN_LEN  = 15,
    parameter int NB_COLUMNS = 30,
    parameter int MUX_SETTLE = 8,
    parameter int TIMEOUT    = 4096
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [4:0]                      column,
    input  logic [CONF_WIDTH-1:0]           expected_conf,
    input  logic                            driver_sclk,
    input  logic                            driver_sout,
    output logic [4:0]                      driver_sout_mux,
    output logic                            busy,
    output logic                            done,
    output logic                            match,
    output logic                            timeout,
    output logic [$clog2(CHAIN_LEN+1)-1:0]  mismatch_count,
    output logic [$clog2(CHAIN_LEN)-1:0]    first_bad_index,
    output logic [CONF_WIDTH-1:0]           captured_conf
);

    localparam int IDX_W  = $clog2(CHAIN_LEN + 1);
    localparam int FBI_W  = $clog2(CHAIN_LEN);
    localparam int BIT_W  = $clog2(CONF_WIDTH);
    localparam int SET_W  = $clog2(MUX_SETTLE + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    localparam logic [5:0]        NB_COLS_6   = 6'(NB_COLUMNS);
    localparam logic [IDX_W-1:0]  LAST_WORD   = IDX_W'(CHAIN_LEN - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT    = BIT_W'(CONF_WIDTH - 1);
    localparam logic [SET_W-1:0]  LAST_SETTLE = SET_W'(MUX_SETTLE - 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT  = IDLE_W'(TIMEOUT);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETTLE  = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_CHECK   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]            state, state_next;
    logic                  sout_s1, sout_s2;
    logic                  sclk_s1, sclk_s2, sclk_s3;
    logic                  sclk_rise, accept, idle_expired, word_diff;
    logic [SET_W-1:0]      settle_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [IDX_W-1:0]      word_idx;
    logic [IDLE_W-1:0]     idle_cnt;
    logic [CONF_WIDTH-1:0] shift_reg, exp_reg;

    // SCLK goes through the same two-flop delay as SOUT so the sampled bit lines up with its edge
    assign sclk_rise    = sclk_s2 & ~sclk_s3;
    assign accept       = start && ({1'b0, column} < NB_COLS_6);
    assign idle_expired = idle_cnt >= IDLE_LIMIT;
    assign word_diff    = shift_reg != exp_reg;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (accept) state_next = S_SETTLE;
            S_SETTLE:  if (settle_cnt == LAST_SETTLE) state_next = S_CAPTURE;
            S_CAPTURE: begin
                if (idle_expired)                          state_next = S_DONE;
                else if (sclk_rise && bit_cnt == LAST_BIT) state_next = S_CHECK;
            end
            S_CHECK:   state_next = (word_idx == LAST_WORD) ? S_DONE : S_CAPTURE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sout_s1 <= 1'b0; sout_s2 <= 1'b0;
            sclk_s1 <= 1'b0; sclk_s2 <= 1'b0; sclk_s3 <= 1'b0;
            driver_sout_mux <= '0;
            match           <= 1'b0;
            timeout         <= 1'b0;
            mismatch_count  <= '0;
            first_bad_index <= '0;
            captured_conf   <= '0;
            settle_cnt      <= '0;
            bit_cnt         <= '0;
            word_idx        <= '0;
            idle_cnt        <= '0;
            shift_reg       <= '0;
            exp_reg         <= '0;
        end else begin
            sout_s1 <= driver_sout; sout_s2 <= sout_s1;
            sclk_s1 <= driver_sclk; sclk_s2 <= sclk_s1; sclk_s3 <= sclk_s2;
            case (state)
                S_IDLE: if (accept) begin
                    driver_sout_mux <= column;
                    exp_reg         <= expected_conf;
                    match           <= 1'b0;
                    timeout         <= 1'b0;
                    mismatch_count  <= '0;
                    first_bad_index <= '0;
                    captured_conf   <= '0;
                    settle_cnt      <= '0;
                    bit_cnt         <= '0;
                    word_idx        <= '0;
                    idle_cnt        <= '0;
                    shift_reg       <= '0;
                end
                S_SETTLE: settle_cnt <= settle_cnt + 1'b1;
                S_CAPTURE, S_CHECK: begin
                    // shifting continues in CHECK so a bit arriving there is kept
                    if (sclk_rise) begin
                        shift_reg <= {shift_reg[CONF_WIDTH-2:0], sout_s2};
                        bit_cnt   <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
                        idle_cnt  <= '0;
                    end else if (!idle_expired) begin
                        idle_cnt  <= idle_cnt + 1'b1;
                    end
                    if (state == S_CAPTURE && idle_expired) begin
                        timeout <= 1'b1;
                        match   <= 1'b0;
                    end
                    if (state == S_CHECK) begin
                        captured_conf <= shift_reg;
                        word_idx      <= word_idx + 1'b1;
                        if (word_diff) begin
                            mismatch_count <= mismatch_count + 1'b1;
                            if (mismatch_count == '0)
                                first_bad_index <= word_idx[FBI_W-1:0];
                        end
                        // result is settled here so it is already valid while done is high
                        if (word_idx == LAST_WORD)
                            match <= (mismatch_count == '0) && !word_diff;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_driver_sout_reader.sv
// Directed self-checking bench for driver_sout_reader.
`default_nettype none

module tb_driver_sout_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  column = '0;
    logic [47:0] expected_conf = '0;
    logic        driver_sclk = 1'b0;
    logic        driver_sout = 1'b0;
    logic [4:0]  driver_sout_mux;
    logic        busy, done, match, timeout;
    logic [3:0]  mismatch_count;
    logic [3:0]  first_bad_index;
    logic [47:0] captured_conf;

    int tests = 0;
    int fails = 0;

    localparam logic [47:0] EXP_A = 48'hA5A5_0F0F_1234;
    localparam logic [47:0] EXP_B = 48'h1357_9BDF_2468;

    driver_sout_reader dut (
        .clk(clk), .rst(rst), .start(start), .column(column),
        .expected_conf(expected_conf), .driver_sclk(driver_sclk),
        .driver_sout(driver_sout), .driver_sout_mux(driver_sout_mux),
        .busy(busy), .done(done), .match(match), .timeout(timeout),
        .mismatch_count(mismatch_count), .first_bad_index(first_bad_index),
        .captured_conf(captured_conf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [4:0] col, input logic [47:0] exp);
        @(negedge clk);
        start = 1'b1; column = col; expected_conf = exp;
        @(negedge clk);
        start = 1'b0;
    endtask

    // SCLK period of 4 clk cycles; SOUT is set while SCLK is low
    task automatic send_bit(input logic b);
        @(negedge clk); driver_sclk = 1'b0; driver_sout = b;
        @(negedge clk);
        @(negedge clk); driver_sclk = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [47:0] w);
        for (int i = 47; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic wait_done(input int limit, output bit got);
        got = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
    endtask

    bit got;
    logic [47:0] w;

    initial begin
        // reset and hold
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_done", done, 0);
        end
        check("rst_busy", busy, 0);
        check("rst_mux", driver_sout_mux, 0);
        check("rst_match", match, 0);
        check("rst_timeout", timeout, 0);
        check("rst_mcount", mismatch_count, 0);
        check("rst_fbi", first_bad_index, 0);
        check("rst_captured", captured_conf, 0);

        // clean run, column 7
        pulse_start(5'd7, EXP_A);
        check("busy_after_start", busy, 1);
        check("mux_col7", driver_sout_mux, 7);
        repeat (12) @(negedge clk);
        for (int k = 0; k < 15; k++) send_word(EXP_A);
        wait_done(100, got);
        check("clean_done_seen", got, 1);
        check("clean_match", match, 1);
        check("clean_mcount", mismatch_count, 0);
        check("clean_timeout", timeout, 0);
        check("clean_captured", captured_conf, EXP_A);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);

        // words 3 and 9 have bit 0 flipped
        pulse_start(5'd7, EXP_A);
        repeat (12) @(negedge clk);
        for (int k = 0; k < 15; k++) begin
            w = EXP_A;
            if (k == 3 || k == 9) w[0] = ~w[0];
            send_word(w);
        end
        wait_done(100, got);
        check("bad_done_seen", got, 1);
        check("bad_match", match, 0);
        check("bad_mcount", mismatch_count, 2);
        check("bad_fbi", first_bad_index, 3);
        check("bad_captured", captured_conf, EXP_A);

        // SCLK stops after 100 bits
        pulse_start(5'd7, EXP_A);
        repeat (12) @(negedge clk);
        for (int i = 0; i < 100; i++) send_bit(EXP_A[47 - (i % 48)]);
        wait_done(4096 + 200, got);
        check("to_done_seen", got, 1);
        check("to_timeout", timeout, 1);
        check("to_match", match, 0);
        check("to_mcount", mismatch_count, 0);
        @(negedge clk);
        check("to_timeout_held", timeout, 1);

        // out-of-range column while idle
        pulse_start(5'd30, EXP_B);
        check("col30_busy", busy, 0);
        check("col30_mux", driver_sout_mux, 7);

        // start while busy is ignored, then reset mid-capture
        pulse_start(5'd12, EXP_B);
        check("mux_col12", driver_sout_mux, 12);
        pulse_start(5'd3, EXP_A);
        check("busy_start_mux", driver_sout_mux, 12);
        repeat (12) @(negedge clk);
        for (int i = 0; i < 20; i++) send_bit(EXP_B[47 - i]);
        check("mid_busy", busy, 1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_mux", driver_sout_mux, 0);
        wait_done(20, got);
        check("rst_mid_no_done", got, 0);

        // following run completes normally
        pulse_start(5'd5, EXP_B);
        repeat (12) @(negedge clk);
        for (int k = 0; k < 15; k++) send_word(EXP_B);
        wait_done(100, got);
        check("post_done_seen", got, 1);
        check("post_match", match, 1);
        check("post_mux", driver_sout_mux, 5);
        check("post_captured", captured_conf, EXP_B);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
